axi_master_cxl: RTL and testbench

AXI_MASTER_CXL -- requirements
Module: axi_master_cxl

---
 rtl/axi_master_cxl.sv | 184 ++++++++++++++++++
 tb/tb_axi_master_cxl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_cxl.sv
// Single-outstanding AXI master that turns cache-line fill/evict requests into
// AR/R or AW/W/B transactions and returns one tagged response per request.
module axi_master_cxl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int ID_W   = 16,
    parameter int TAG_W  = 64,
    parameter int AXI_ID = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_write,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic [TAG_W-1:0]          resp_tag,
    output logic                      resp_err,
    output logic [ID_W-1:0]           arid,
    output logic [ADDR_W-1:0]         araddr,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [ID_W-1:0]           rid,
    input  logic [TAG_W+DATA_W-1:0]   rdata,
    input  logic                      rvalid,
    output logic                      rready,
    output logic [ID_W-1:0]           awid,
    output logic [ADDR_W-1:0]         awaddr,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [ID_W-1:0]           wid,
    output logic [DATA_W-1:0]         wdata,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [ID_W-1:0]           bid,
    input  logic                      bvalid,
    output logic                      bready,
    output logic [15:0]               rd_count,
    output logic [15:0]               wr_count
);

    localparam logic [ID_W-1:0] LP_ID = ID_W'(AXI_ID);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RESP} state_t;

    state_t              r_state;
    logic                r_req_ready, r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
    logic                r_resp_valid, r_resp_write, r_resp_err, r_aw_done, r_w_done;
    logic [ADDR_W-1:0]   r_araddr, r_awaddr;
    logic [DATA_W-1:0]   r_wdata, r_resp_rdata;
    logic [TAG_W-1:0]    r_resp_tag;
    logic [15:0]         r_rd_count, r_wr_count;

    logic w_aw_hs, w_w_hs, w_aw_ok, w_w_ok;

    // A channel counts as finished either from an earlier handshake or one happening now.
    assign w_aw_hs = r_awvalid & awready;
    assign w_w_hs  = r_wvalid & wready;
    assign w_aw_ok = r_aw_done | w_aw_hs;
    assign w_w_ok  = r_w_done | w_w_hs;

    // NOTE: every register, including wide data, is reset so no X can leak onto the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_write <= 1'b0;
            r_resp_err   <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_araddr     <= '0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
            r_resp_tag   <= '0;
            r_rd_count   <= '0;
            r_wr_count   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; later writes in the same branch win.
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready  <= 1'b0;
                        r_resp_write <= req_write;
                        r_araddr     <= {req_addr[ADDR_W-1:6], 6'b0};
                        r_awaddr     <= {req_addr[ADDR_W-1:6], 6'b0};
                        r_wdata      <= req_wdata;
                        if (req_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_AW_W;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        r_rready     <= 1'b0;
                        r_resp_rdata <= rdata[DATA_W-1:0];
                        r_resp_tag   <= rdata[TAG_W+DATA_W-1:DATA_W];
                        r_resp_err   <= (rid != LP_ID);
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_AW_W: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= S_B;
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        r_bready     <= 1'b0;
                        r_resp_err   <= (bid != LP_ID);
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        if (r_resp_write) r_wr_count <= r_wr_count + 16'd1;
                        else              r_rd_count <= r_rd_count + 16'd1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_write = r_resp_write;
    assign resp_rdata = r_resp_rdata;
    assign resp_tag   = r_resp_tag;
    assign resp_err   = r_resp_err;
    assign arid       = LP_ID;
    assign awid       = LP_ID;
    assign wid        = LP_ID;
    assign araddr     = r_araddr;
    assign arvalid    = r_arvalid;
    assign rready     = r_rready;
    assign awaddr     = r_awaddr;
    assign awvalid    = r_awvalid;
    assign wdata      = r_wdata;
    assign wvalid     = r_wvalid;
    assign bready     = r_bready;
    assign rd_count   = r_rd_count;
    assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_axi_master_cxl.sv
// Bench for axi_master_cxl: directed scenarios plus random fill/evict traffic
// against a transaction-level model of addresses, responses and counters.
module tb_axi_master_cxl;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int ID_W   = 16;
    localparam int TAG_W  = 64;
    localparam int AXI_ID = 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_valid, req_ready, req_write;
    logic [ADDR_W-1:0]       req_addr;
    logic [DATA_W-1:0]       req_wdata;
    logic                    resp_valid, resp_ready, resp_write, resp_err;
    logic [DATA_W-1:0]       resp_rdata;
    logic [TAG_W-1:0]        resp_tag;
    logic [ID_W-1:0]         arid, awid, wid, rid, bid;
    logic [ADDR_W-1:0]       araddr, awaddr;
    logic                    arvalid, arready, rvalid, rready;
    logic [TAG_W+DATA_W-1:0] rdata;
    logic                    awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DATA_W-1:0]       wdata;
    logic [15:0]             rd_count, wr_count;

    axi_master_cxl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .TAG_W(TAG_W), .AXI_ID(AXI_ID)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_rdata(resp_rdata), .resp_tag(resp_tag), .resp_err(resp_err),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bvalid(bvalid), .bready(bready),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: completed counts and the last read payload.
    int                exp_rd = 0;
    int                exp_wr = 0;
    logic [DATA_W-1:0] last_rdata = '0;
    logic [TAG_W-1:0]  last_tag   = '0;

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic send_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int t = 0;
        while (req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_wait: got %b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic check_resp(input logic wr, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] tg,
                              input logic err, input int stall);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_write !== wr || resp_err !== err) begin
            n_fail++;
            $display("FAIL resp_ctrl: got valid=%b write=%b err=%b expected 1 %b %b",
                     resp_valid, resp_write, resp_err, wr, err);
        end
        n_checks++;
        if (resp_rdata !== d || resp_tag !== tg) begin
            n_fail++;
            $display("FAIL resp_data: got tag=%h data=%h expected tag=%h data=%h", resp_tag, resp_rdata, tg, d);
        end
        for (int s = 0; s < stall; s++) begin
            resp_ready = 1'b0;
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== d || resp_tag !== tg ||
                resp_err !== err || resp_write !== wr) begin
                n_fail++;
                $display("FAIL resp_stall: got valid=%b req_ready=%b err=%b expected 1 0 %b",
                         resp_valid, req_ready, resp_err, err);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        if (wr) exp_wr = (exp_wr + 1) % 65536;
        else    exp_rd = (exp_rd + 1) % 65536;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_done: got valid=%b req_ready=%b expected 0 1", resp_valid, req_ready);
        end
        n_checks++;
        if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr)) begin
            n_fail++;
            $display("FAIL counters: got rd=%0d wr=%0d expected rd=%0d wr=%0d", rd_count, wr_count, exp_rd, exp_wr);
        end
    endtask

    task automatic run_read(input logic [ADDR_W-1:0] a, input int ar_dly, input int r_dly,
                            input logic [ID_W-1:0] id, input logic [TAG_W-1:0] tg,
                            input logic [DATA_W-1:0] d, input int stall);
        logic [ADDR_W-1:0] exp_addr;
        exp_addr = a & ~64'h3F;
        send_req(1'b0, a, rand_data());
        for (int c = 0; c <= ar_dly; c++) begin
            n_checks++;
            if (arvalid !== 1'b1 || araddr !== exp_addr || arid !== ID_W'(AXI_ID)) begin
                n_fail++;
                $display("FAIL ar_phase: got arvalid=%b araddr=%h arid=%h expected 1 %h %h",
                         arvalid, araddr, arid, exp_addr, ID_W'(AXI_ID));
            end
            arready = (c == ar_dly);
            @(negedge clk);
        end
        arready = 1'b0;
        for (int c = 0; c <= r_dly; c++) begin
            n_checks++;
            if (rready !== 1'b1 || arvalid !== 1'b0 || resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL r_wait: got rready=%b arvalid=%b resp_valid=%b expected 1 0 0",
                         rready, arvalid, resp_valid);
            end
            if (c == r_dly) begin
                bvalid = 1'b0;
                rvalid = 1'b1;
                rid    = id;
                rdata  = {tg, d};
            end else begin
                bvalid = 1'b1;
                bid    = ID_W'($urandom());
            end
            @(negedge clk);
        end
        rvalid = 1'b0;
        bvalid = 1'b0;
        last_rdata = d;
        last_tag   = tg;
        check_resp(1'b0, d, tg, id != ID_W'(AXI_ID), stall);
    endtask

    task automatic run_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input logic [ID_W-1:0] id, input int stall);
        logic [ADDR_W-1:0] exp_addr;
        int aw_beats = 0;
        int w_beats  = 0;
        int last_c;
        int t = 0;
        exp_addr = a & ~64'h3F;
        last_c   = (aw_dly > w_dly) ? aw_dly : w_dly;
        send_req(1'b1, a, d);
        for (int c = 0; c <= last_c; c++) begin
            n_checks++;
            if (awvalid !== (c <= aw_dly) || wvalid !== (c <= w_dly) || awaddr !== exp_addr ||
                wdata !== d || awid !== ID_W'(AXI_ID) || wid !== ID_W'(AXI_ID)) begin
                n_fail++;
                $display("FAIL aw_w_phase c=%0d: got awvalid=%b wvalid=%b awaddr=%h expected %b %b %h",
                         c, awvalid, wvalid, awaddr, c <= aw_dly, c <= w_dly, exp_addr);
            end
            awready = (c == aw_dly);
            wready  = (c == w_dly);
            rvalid  = 1'b1;
            if (awvalid && awready) aw_beats++;
            if (wvalid && wready)   w_beats++;
            @(negedge clk);
        end
        awready = 1'b0;
        wready  = 1'b0;
        while (bready !== 1'b1 && t < 3) begin
            if (awvalid) aw_beats += 100;
            if (wvalid)  w_beats  += 100;
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bready !== 1'b1 || aw_beats != 1 || w_beats != 1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL b_entry: got bready=%b aw_beats=%0d w_beats=%0d expected 1 1 1",
                     bready, aw_beats, w_beats);
        end
        for (int c = 0; c <= b_dly; c++) begin
            if (c == b_dly) begin
                rvalid = 1'b0;
                bvalid = 1'b1;
                bid    = id;
            end
            @(negedge clk);
        end
        bvalid = 1'b0;
        rvalid = 1'b0;
        check_resp(1'b1, last_rdata, last_tag, id != ID_W'(AXI_ID), stall);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || arvalid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0 ||
            rready !== 1'b0 || bready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got req_ready=%b arvalid=%b awvalid=%b wvalid=%b resp_valid=%b expected all 0",
                     req_ready, arvalid, awvalid, wvalid, resp_valid);
        end
        n_checks++;
        if (araddr !== '0 || awaddr !== '0 || wdata !== '0 || resp_rdata !== '0 || resp_tag !== '0 ||
            rd_count !== 16'd0 || wr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: got araddr=%h awaddr=%h rd=%0d wr=%0d expected 0", araddr, awaddr, rd_count, wr_count);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got req_ready=%b expected 1", req_ready);
        end
    endtask

    task automatic test_ignore();
        rvalid = 1'b1;
        rid    = ID_W'(AXI_ID);
        rdata  = {rand64(), rand_data()};
        bvalid = 1'b1;
        bid    = ID_W'(AXI_ID);
        repeat (3) @(negedge clk);
        rvalid = 1'b0;
        bvalid = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== last_rdata || resp_tag !== last_tag) begin
            n_fail++;
            $display("FAIL ignore_idle: got resp_valid=%b req_ready=%b tag=%h expected 0 1 %h",
                     resp_valid, req_ready, resp_tag, last_tag);
        end
    endtask

    task automatic test_fill();
        run_read(64'h1000_007F, 0, 0, ID_W'(1), 64'hA5, 512'h1234, 0);
    endtask

    task automatic test_evict();
        run_write(rand64(), rand_data(), 2, 2, 1, ID_W'(1), 0);
    endtask

    task automatic test_skew();
        run_write(rand64(), rand_data(), 3, 0, 0, ID_W'(1), 0);
        run_write(rand64(), rand_data(), 0, 4, 2, ID_W'(1), 0);
    endtask

    task automatic test_id_error();
        run_read(rand64(), 1, 2, ID_W'(2), rand64(), rand_data(), 0);
        run_write(rand64(), rand_data(), 1, 1, 0, ID_W'(0), 0);
    endtask

    task automatic test_stall();
        run_read(rand64(), 0, 1, ID_W'(1), rand64(), rand_data(), 5);
        run_write(rand64(), rand_data(), 1, 0, 1, ID_W'(1), 5);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [ID_W-1:0] id;
            id = ($urandom_range(0, 3) == 0) ? ID_W'($urandom_range(0, 7)) : ID_W'(AXI_ID);
            if ($urandom_range(0, 1) == 1)
                run_write(rand64(), rand_data(), $urandom_range(0, 4), $urandom_range(0, 4),
                          $urandom_range(0, 3), id, $urandom_range(0, 2));
            else
                run_read(rand64(), $urandom_range(0, 4), $urandom_range(0, 4), id, rand64(),
                         rand_data(), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid();
        send_req(1'b0, rand64(), '0);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_rd     = 0;
        exp_wr     = 0;
        last_rdata = '0;
        last_tag   = '0;
        n_checks++;
        if (rready !== 1'b0 || arvalid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0 ||
            araddr !== '0 || resp_rdata !== '0 || rd_count !== 16'd0 || wr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got rready=%b arvalid=%b req_ready=%b araddr=%h rd=%0d expected 0",
                     rready, arvalid, req_ready, araddr, rd_count);
        end
        rvalid = 1'b1;
        rid    = ID_W'(AXI_ID);
        rdata  = {rand64(), rand_data()};
        @(negedge clk);
        rvalid = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || rd_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_release: got req_ready=%b resp_valid=%b rd=%0d expected 1 0 0",
                     req_ready, resp_valid, rd_count);
        end
        run_read(rand64(), 1, 1, ID_W'(1), rand64(), rand_data(), 1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        arready    = 1'b0;
        rid        = '0;
        rdata      = '0;
        rvalid     = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bid        = '0;
        bvalid     = 1'b0;
        @(negedge clk);
        test_reset();
        test_ignore();
        test_fill();
        test_evict();
        test_skew();
        test_id_error();
        test_stall();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
